// File: rtl/fetch_iq_if.sv
// Packet type and fe0/fe1 bundle for the fetch instruction queue.
// The master modport is the queue side; the slave modport is the icache/decode side.
package fetch_iq_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef SIMULATION
    logic [31:0] simid;
`endif
  } t_instr_pkt;
endpackage

interface fetch_iq_if #(
  parameter int DEPTH = 4
);
  import fetch_iq_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             ic_valid_fe0;
  logic [31:0]      ic_instr_fe0;
  logic [31:0]      ic_pc_fe0;
  logic             ic_ready_fe0;
  logic             stall;
  logic             br_mispred_rb1;
  logic             valid_fe1;
  t_instr_pkt       instr_fe1;
  logic [CNT_W-1:0] iq_count;

  modport master (
    input  ic_valid_fe0, ic_instr_fe0, ic_pc_fe0, stall, br_mispred_rb1,
    output ic_ready_fe0, valid_fe1, instr_fe1, iq_count
  );

  modport slave (
    output ic_valid_fe0, ic_instr_fe0, ic_pc_fe0, stall, br_mispred_rb1,
    input  ic_ready_fe0, valid_fe1, instr_fe1, iq_count
  );
endinterface

// File: rtl/fetch_iq.sv
// Fetch-side instruction queue: buffers icache returns and presents the head packet to decode.
// Circular buffer; outputs come from registered state only, flush drops everything queued.
module fetch_iq
  import fetch_iq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  fetch_iq_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  t_instr_pkt       mem [DEPTH];
  t_instr_pkt       wr_pkt;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, valid, flush, push, pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign valid = (count != '0);
  assign flush = bus.br_mispred_rb1;
  // Flush beats both push and pop in the same cycle.
  assign push  = bus.ic_valid_fe0 & ~full & ~flush;
  assign pop   = valid & ~bus.stall & ~flush;

`ifdef SIMULATION
  logic [31:0] fid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  fid <= '0;
    else if (push) fid <= fid + 32'd1;
`endif

  always_comb begin
    wr_pkt       = '0;
    wr_pkt.instr = bus.ic_instr_fe0;
    wr_pkt.pc    = bus.ic_pc_fe0;
`ifdef SIMULATION
    wr_pkt.simid = fid;
`endif
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_pkt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head slot is never overwritten while occupied, so a stalled head stays put.
  // Empty queue presents zero rather than stale or uninitialised storage.
  assign bus.ic_ready_fe0 = ~full;
  assign bus.valid_fe1    = valid;
  assign bus.instr_fe1    = valid ? mem[rd_ptr] : '0;
  assign bus.iq_count     = count;

`ifndef SYNTHESIS
  a_cnt_max:  assert property (@(posedge clk) disable iff (!reset_n) count <= CNT_W'(DEPTH));
  a_no_ovf:   assert property (@(posedge clk) disable iff (!reset_n) push |-> !full);
  a_no_unf:   assert property (@(posedge clk) disable iff (!reset_n) pop |-> valid);
  a_hold:     assert property (@(posedge clk) disable iff (!reset_n)
                (valid & bus.stall & ~flush) |=> (valid && $stable(bus.instr_fe1)));
`endif
endmodule

// File: tb/tb_fetch_iq.sv
// Directed + random bench for fetch_iq against a queue-based reference model.
module tb_fetch_iq;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ref_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  ref_t q[$];

  fetch_iq_if #(.DEPTH(DEPTH)) bus ();
  fetch_iq #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_v = (q.size() != 0);
    chk("valid_fe1", 64'(bus.valid_fe1), 64'(exp_v));
    chk("iq_count", 64'(bus.iq_count), 64'(q.size()));
    chk("ic_ready_fe0", 64'(bus.ic_ready_fe0), 64'(q.size() != DEPTH));
    if (exp_v) begin
      chk("head_instr", 64'(bus.instr_fe1.instr), 64'(q[0].instr));
      chk("head_pc", 64'(bus.instr_fe1.pc), 64'(q[0].pc));
    end else begin
      chk("empty_instr", 64'(bus.instr_fe1.instr), 64'd0);
      chk("empty_pc", 64'(bus.instr_fe1.pc), 64'd0);
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, check at next negedge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    ref_t e;
    logic did_push, did_pop;
    e.instr = $urandom;
    e.pc    = pc;
    bus.ic_valid_fe0   = v;
    bus.ic_instr_fe0   = e.instr;
    bus.ic_pc_fe0      = pc;
    bus.stall          = st;
    bus.br_mispred_rb1 = fl;
    if (fl) q.delete();
    else begin
      did_push = v && (q.size() < DEPTH);
      did_pop  = (q.size() != 0) && !st;
      if (did_pop) void'(q.pop_front());
      if (did_push) q.push_back(e);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] hold_pc;
    bus.ic_valid_fe0 = 1'b0; bus.ic_instr_fe0 = '0; bus.ic_pc_fe0 = '0;
    bus.stall = 1'b0; bus.br_mispred_rb1 = 1'b0;
    @(negedge clk); @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // 1: single push, visible next cycle, then gone
    cyc(1'b1, 32'h1000, 1'b0, 1'b0);
    chk("t1_pc", 64'(bus.instr_fe1.pc), 64'h1000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t1_drain", 64'(bus.valid_fe1), 64'd0);

    // 2: fill under stall, 5th push ignored, drain in order
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h1000 + 32'(4*i), 1'b1, 1'b0);
    chk("t2_full_cnt", 64'(bus.iq_count), 64'd4);
    chk("t2_full_rdy", 64'(bus.ic_ready_fe0), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 64'(bus.instr_fe1.pc), 64'(32'h1000 + 32'(4*i)));
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
    end

    // 3: steady push+pop, occupancy stays 1 across pointer wraps
    cyc(1'b1, 32'h3000, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 32'h3000 + 32'(4*i), 1'b0, 1'b0);
      chk("t3_cnt", 64'(bus.iq_count), 64'd1);
      chk("t3_pc", 64'(bus.instr_fe1.pc), 64'(32'h3000 + 32'(4*i)));
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // 4: flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h4000 + 32'(4*i), 1'b1, 1'b0);
    cyc(1'b1, 32'h4100, 1'b0, 1'b1);
    chk("t4_cnt", 64'(bus.iq_count), 64'd0);
    chk("t4_valid", 64'(bus.valid_fe1), 64'd0);
    cyc(1'b1, 32'h2000, 1'b1, 1'b0);
    chk("t4_next_pc", 64'(bus.instr_fe1.pc), 64'h2000);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // 5: head held through a long stall while pushes continue
    cyc(1'b1, 32'h5000, 1'b1, 1'b0);
    hold_pc = q[0].pc;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 32'h5000 + 32'(4*i), 1'b1, 1'b0);
      chk("t5_hold", 64'(bus.instr_fe1.pc), 64'(hold_pc));
    end

    // 6: asynchronous reset with two entries queued
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h6000, 1'b1, 1'b0);
    cyc(1'b1, 32'h6004, 1'b1, 1'b0);
    bus.ic_valid_fe0 = 1'b0; bus.stall = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", 64'(bus.valid_fe1), 64'd0);
    chk("t6_cnt", 64'(bus.iq_count), 64'd0);
    chk("t6_rdy", 64'(bus.ic_ready_fe0), 64'd1);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(3) != 0), pc, ($urandom_range(2) == 0), ($urandom_range(15) == 0));
      pc = pc + 32'd4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
